aes_addroundkey_wddl: RTL and testbench

AES_ADDROUNDKEY_WDDL -- requirements
Module: aes_addroundkey_wddl

---
 rtl/aes_wddl_pkg.sv | 22 ++
 rtl/wddl_xor2_8.sv | 16 +
 rtl/aes_addroundkey_wddl.sv | 135 +++++++++++++
 tb/tb_aes_addroundkey_wddl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_wddl_pkg.sv
// Shared types and sizes for the dual-rail (WDDL) AddRoundKey block.
package aes_wddl_pkg;

    localparam int COL_W   = 32;
    localparam int COL_NUM = 4;
    localparam int STATE_W = COL_W * COL_NUM;

    // Block phases: collect a column, precharge, present the state, clear.
    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_PRE  = 2'd1,
        ST_FULL = 2'd2,
        ST_CLR  = 2'd3
    } wddl_state_e;

    // Pick 32-bit word idx out of a 128-bit vector; word 0 is the top word.
    function automatic logic [COL_W-1:0] key_word(input logic [STATE_W-1:0] key,
                                                 input logic [1:0]         idx);
        key_word = key[STATE_W-1-COL_W*int'(idx) -: COL_W];
    endfunction

endpackage

// File: rtl/wddl_xor2_8.sv
// Eight-bit WDDL XOR cell: both rails are built from positive AND/OR logic,
// so a 0/0 precharge on the inputs yields a 0/0 precharge on the outputs.
module wddl_xor2_8 (
    input  logic [7:0] a_p,
    input  logic [7:0] a_n,
    input  logic [7:0] b_p,
    input  logic [7:0] b_n,
    output logic [7:0] y_p,
    output logic [7:0] y_n
);

    // True rail is 1 when exactly one operand is 1; false rail when they agree.
    assign y_p = (a_p & b_n) | (a_n & b_p);
    assign y_n = (a_p & b_p) | (a_n & b_n);

endmodule

// File: rtl/aes_addroundkey_wddl.sv
// Dual-rail AddRoundKey: collects four MixColumns columns, XORs each with
// the matching round-key word in WDDL form, and presents the 128-bit state.
// Handshake: a column moves when in_valid && in_ready on a rising clk edge;
// the state moves when out_valid && out_ready on a rising clk edge.
module aes_addroundkey_wddl
    import aes_wddl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COL_W-1:0]   col_p,
    input  logic [COL_W-1:0]   col_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] key_p,
    input  logic [STATE_W-1:0] key_n,
    output logic [STATE_W-1:0] out_p,
    output logic [STATE_W-1:0] out_n,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               rail_err,
    output logic [1:0]         dbg_state
);

    wddl_state_e        state;
    wddl_state_e        state_nxt;
    logic [1:0]         col_cnt;
    logic [STATE_W-1:0] reg_p;
    logic [STATE_W-1:0] reg_n;
    logic [COL_W-1:0]   kw_p;
    logic [COL_W-1:0]   kw_n;
    logic [COL_W-1:0]   xa_p;
    logic [COL_W-1:0]   xa_n;
    logic [COL_W-1:0]   xb_p;
    logic [COL_W-1:0]   xb_n;
    logic [COL_W-1:0]   xy_p;
    logic [COL_W-1:0]   xy_n;
    logic               accept;
    logic               col_bad;

    assign kw_p      = key_word(key_p, col_cnt);
    assign kw_n      = key_word(key_n, col_cnt);
    assign in_ready  = (state == ST_ACC);
    assign accept    = in_ready && in_valid;
    assign out_valid = (state == ST_FULL);
    assign dbg_state = state;

    // A bit whose two rails agree is not a valid dual-rail symbol.
    assign col_bad = (|(col_p ~^ col_n)) | (|(kw_p ~^ kw_n));

    // Cell inputs carry data only while collecting; everywhere else they sit
    // at the 0/0 precharge so every evaluation starts from the same level.
    always_comb begin
        xa_p = '0;
        xa_n = '0;
        xb_p = '0;
        xb_n = '0;
        if (state == ST_ACC) begin
            xa_p = col_p;
            xa_n = col_n;
            xb_p = kw_p;
            xb_n = kw_n;
        end
    end

    // One WDDL cell per byte of the column.
    for (genvar b = 0; b < COL_W / 8; b++) begin : g_byte
        wddl_xor2_8 u_xor (
            .a_p (xa_p[8*b +: 8]),
            .a_n (xa_n[8*b +: 8]),
            .b_p (xb_p[8*b +: 8]),
            .b_n (xb_n[8*b +: 8]),
            .y_p (xy_p[8*b +: 8]),
            .y_n (xy_n[8*b +: 8])
        );
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_ACC;
        else        state <= state_nxt;
    end

    // FSM next-state: every column is followed by one precharge cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:  if (in_valid) state_nxt = ST_PRE;
            ST_PRE:  state_nxt = (col_cnt == 2'd3) ? ST_FULL : ST_ACC;
            ST_FULL: if (out_ready) state_nxt = ST_CLR;
            ST_CLR:  state_nxt = ST_ACC;
            default: state_nxt = ST_ACC;
        endcase
    end

    // Rail registers, column counter and sticky encoding-error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_p    <= '0;
            reg_n    <= '0;
            col_cnt  <= 2'd0;
            rail_err <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        reg_p[STATE_W-1-COL_W*int'(col_cnt) -: COL_W] <= xy_p;
                        reg_n[STATE_W-1-COL_W*int'(col_cnt) -: COL_W] <= xy_n;
                        if (col_bad) rail_err <= 1'b1;
                    end
                end
                ST_PRE: begin
                    // The last column leaves the count at 3; it wraps in CLR.
                    if (col_cnt != 2'd3) col_cnt <= col_cnt + 2'd1;
                end
                ST_CLR: begin
                    reg_p   <= '0;
                    reg_n   <= '0;
                    col_cnt <= 2'd0;
                end
                default: ;
            endcase
        end
    end

    // Outputs stay precharged except while the full state is presented.
    always_comb begin
        out_p = '0;
        out_n = '0;
        if (state == ST_FULL) begin
            out_p = reg_p;
            out_n = reg_n;
        end
    end

endmodule

// File: tb/tb_aes_addroundkey_wddl.sv
// Bench for aes_addroundkey_wddl: random and directed blocks checked every
// cycle against a transaction-level model, plus FIPS-197 literal vectors.
module tb_aes_addroundkey_wddl;

    logic         clk;
    logic         rst_n;
    logic [31:0]  col_p;
    logic [31:0]  col_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key_p;
    logic [127:0] key_n;
    logic [127:0] out_p;
    logic [127:0] out_n;
    logic         out_valid;
    logic         out_ready;
    logic         rail_err;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_first;
    int t_valid;

    localparam logic [127:0] FIPS_COLS = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] FIPS_KEY  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] FIPS_OUT  = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;

    aes_addroundkey_wddl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_p     (col_p),
        .col_n     (col_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_p     (key_p),
        .key_n     (key_n),
        .out_p     (out_p),
        .out_n     (out_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rail_err  (rail_err),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a block is "columns taken so far" plus a flag for
    // the pending precharge slot, then a presented state, then a clear slot.
    int           m_cols;
    bit           m_pre;
    bit           m_full;
    bit           m_clr;
    bit           m_err;
    logic [127:0] m_p;
    logic [127:0] m_n;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] kp;
        logic [31:0] kn;
        if (!rst_n) begin
            m_cols = 0; m_pre = 0; m_full = 0; m_clr = 0; m_err = 0;
            m_p = '0; m_n = '0;
        end else if (m_clr) begin
            m_clr = 0; m_cols = 0; m_p = '0; m_n = '0;
        end else if (m_full) begin
            if (out_ready) begin m_full = 0; m_clr = 1; end
        end else if (m_pre) begin
            m_pre = 0;
            if (m_cols == 4) m_full = 1;
        end else if (in_valid) begin
            kp = key_p[127-32*m_cols -: 32];
            kn = key_n[127-32*m_cols -: 32];
            // Dual-rail XOR: "1" on the true rail iff exactly one operand is 1.
            m_p[127-32*m_cols -: 32] = (col_p & kn) | (col_n & kp);
            m_n[127-32*m_cols -: 32] = (col_p & kp) | (col_n & kn);
            if ((col_p ~^ col_n) != 0 || (kp ~^ kn) != 0) m_err = 1;
            m_cols++;
            m_pre = 1;
        end
    end

    // Every-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready",  {127'd0, in_ready},  {127'd0, !(m_pre || m_full || m_clr)});
            chk("out_valid", {127'd0, out_valid}, {127'd0, m_full});
            chk("out_p",     out_p, m_full ? m_p : 128'd0);
            chk("out_n",     out_n, m_full ? m_n : 128'd0);
            chk("rail_err",  {127'd0, rail_err},  {127'd0, m_err});
        end
    end

    // Present one column until it is accepted (called just after a posedge).
    task automatic accept_col(input logic [31:0] p, input logic [31:0] n);
        int w;
        col_p = p; col_n = n; in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] cp, input logic [127:0] cn,
                              input logic [127:0] kp, input logic [127:0] kn,
                              input int max_gap, input int ncols);
        key_p = kp; key_n = kn;
        for (int k = 0; k < ncols; k++) begin
            repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
            accept_col(cp[127-32*k -: 32], cn[127-32*k -: 32]);
            if (k == 0) t_first = cyc;
        end
    endtask

    // Wait for out_valid, capture, optionally stall and then drain.
    task automatic wait_out(input int hold, input bit junk, input bit drain,
                            output logic [127:0] cp, output logic [127:0] cn);
        int w;
        out_ready = 1'b0;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL out_valid_timeout: out_valid got 0 expected 1");
        end
        t_valid = cyc;
        cp = out_p; cn = out_n;
        if (junk) begin
            in_valid = 1'b1; col_p = $urandom; col_n = ~col_p;
        end
        if (drain) begin
            repeat (hold) @(posedge clk);
            #1;
            in_valid = 1'b0; out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic rand_word128(output logic [127:0] v);
        v = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        logic [127:0] cp, cn, kp, op, on;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        col_p = '0; col_n = '0; key_p = '0; key_n = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready",  {127'd0, in_ready},  128'd1);
        chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
        chk("reset_out_p",     out_p, 128'd0);
        chk("reset_rail_err",  {127'd0, rail_err},  128'd0);
        @(posedge clk); #1;

        // FIPS-197 round 1, columns back to back, then a 5-cycle stall with
        // in_valid high; out_valid is 7 edges after the first accept edge.
        send_block(FIPS_COLS, ~FIPS_COLS, FIPS_KEY, ~FIPS_KEY, 0, 4);
        wait_out(5, 1'b1, 1'b1, op, on);
        chk("latency", 128'(t_valid - t_first), 128'd7);
        chk("fips_out_p", op, FIPS_OUT);
        chk("fips_out_n", on, ~FIPS_OUT);
        chk("fips_rail_err", {127'd0, rail_err}, 128'd0);

        // Same vector again with gaps: nothing absorbed during the stall.
        send_block(FIPS_COLS, ~FIPS_COLS, FIPS_KEY, ~FIPS_KEY, 3, 4);
        wait_out(2, 1'b0, 1'b1, op, on);
        chk("fips2_out_p", op, FIPS_OUT);
        chk("fips2_out_n", on, ~FIPS_OUT);

        // Random well-formed blocks with random gaps and stalls.
        for (int b = 0; b < 16; b++) begin
            rand_word128(cp); rand_word128(kp);
            send_block(cp, ~cp, kp, ~kp, 3, 4);
            wait_out($urandom_range(0, 3), 1'(b & 1), 1'b1, op, on);
            chk("rand_xor", op, cp ^ kp);
        end

        // Column 1, byte 2 with both rails high: sticky rail_err.
        rand_word128(cp); rand_word128(kp);
        cn = ~cp;
        cp[87:80] = 8'hff; cn[87:80] = 8'hff;
        send_block(cp, cn, kp, ~kp, 1, 4);
        wait_out(1, 1'b0, 1'b1, op, on);
        chk("err_set", {127'd0, rail_err}, 128'd1);
        rand_word128(cp); rand_word128(kp);
        send_block(cp, ~cp, kp, ~kp, 1, 4);
        wait_out(0, 1'b0, 1'b1, op, on);
        chk("err_sticky", {127'd0, rail_err}, 128'd1);
        chk("err_next_block", op, cp ^ kp);

        // Reset after two columns: everything cleared, no residue later.
        rand_word128(cp); rand_word128(kp);
        send_block(cp, ~cp, kp, ~kp, 1, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_p",    out_p, 128'd0);
        chk("midrst_rail_err", {127'd0, rail_err}, 128'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk); #1;
        send_block(FIPS_COLS, ~FIPS_COLS, FIPS_KEY, ~FIPS_KEY, 2, 4);
        wait_out(0, 1'b0, 1'b1, op, on);
        chk("postrst_out_p", op, FIPS_OUT);
        chk("postrst_out_n", on, ~FIPS_OUT);

        // Reset while the state is presented: outputs drop at once.
        send_block(FIPS_COLS, ~FIPS_COLS, FIPS_KEY, ~FIPS_KEY, 0, 4);
        wait_out(0, 1'b0, 1'b0, op, on);
        #2 rst_n = 1'b0;
        #1;
        chk("fullrst_out_p",     out_p, 128'd0);
        chk("fullrst_out_n",     out_n, 128'd0);
        chk("fullrst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("fullrst_in_ready",  {127'd0, in_ready},  128'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
